// File: rtl/lcd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lcd_pkg
// Description : Shared constants, types and helpers for the HD44780 responder:
//               instruction masks, DDRAM line layout, state encoding and the
//               address-counter stepping rules.
// Revision    : 1.0 - initial release
// ============================================================================
package lcd_pkg;

    // Instruction masks: an instruction is identified by its highest set bit
    localparam logic [7:0] OP_CLEAR   = 8'h01;
    localparam logic [7:0] OP_HOME    = 8'h02;
    localparam logic [7:0] OP_ENTRY   = 8'h04;
    localparam logic [7:0] OP_DISPCTL = 8'h08;
    localparam logic [7:0] OP_SHIFT   = 8'h10;
    localparam logic [7:0] OP_FUNCSET = 8'h20;
    localparam logic [7:0] OP_CGRAM   = 8'h40;
    localparam logic [7:0] OP_DDRAM   = 8'h80;

    // DDRAM address map of a 2-line panel
    localparam logic [6:0] LINE0_BASE = 7'h00;
    localparam logic [6:0] LINE1_BASE = 7'h40;
    localparam logic [6:0] LINE_LEN   = 7'd16;
    localparam logic [6:0] LINE_END   = 7'h27;
    localparam logic [6:0] LINE1_END  = LINE1_BASE + LINE_END;

    localparam logic [7:0] SPACE = 8'h20;

    // Physical storage: 2 lines x 16 visible cells
    localparam int DDRAM_DEPTH = 32;
    localparam int ADDR_W      = 5;

    typedef enum logic [1:0] {
        CLEARING = 2'd0,
        IDLE     = 2'd1,
        BUSY     = 2'd2
    } state_t;

    typedef enum logic [3:0] {
        INS_NOP     = 4'd0,
        INS_CLEAR   = 4'd1,
        INS_HOME    = 4'd2,
        INS_ENTRY   = 4'd3,
        INS_DISPCTL = 4'd4,
        INS_SHIFT   = 4'd5,
        INS_FUNCSET = 4'd6,
        INS_CGRAM   = 4'd7,
        INS_DDRAM   = 4'd8
    } instr_t;

    // Classify an instruction byte by its highest set bit
    function automatic instr_t instr_decode(input logic [7:0] d);
        instr_t ins;
        if      ((d & OP_DDRAM)   != 8'h00) ins = INS_DDRAM;
        else if ((d & OP_CGRAM)   != 8'h00) ins = INS_CGRAM;
        else if ((d & OP_FUNCSET) != 8'h00) ins = INS_FUNCSET;
        else if ((d & OP_SHIFT)   != 8'h00) ins = INS_SHIFT;
        else if ((d & OP_DISPCTL) != 8'h00) ins = INS_DISPCTL;
        else if ((d & OP_ENTRY)   != 8'h00) ins = INS_ENTRY;
        else if ((d & OP_HOME)    != 8'h00) ins = INS_HOME;
        else if ((d & OP_CLEAR)   != 8'h00) ins = INS_CLEAR;
        else                                ins = INS_NOP;
        return ins;
    endfunction

    // Step the address counter by one, jumping across the gaps between lines
    function automatic logic [6:0] ac_step(input logic [6:0] a, input logic inc);
        logic [6:0] r;
        if (inc) begin
            if      (a == LINE_END)  r = LINE1_BASE;
            else if (a == LINE1_END) r = LINE0_BASE;
            else                     r = a + 7'd1;
        end else begin
            if      (a == LINE0_BASE) r = LINE1_END;
            else if (a == LINE1_BASE) r = LINE_END;
            else                      r = a - 7'd1;
        end
        return r;
    endfunction

    // Only the first 16 cells of each line are backed by storage
    function automatic logic ac_visible(input logic [6:0] a);
        return (a[6:4] == LINE0_BASE[6:4]) || (a[6:4] == LINE1_BASE[6:4]);
    endfunction

    // Storage index of a visible address: {line, column}
    function automatic logic [ADDR_W-1:0] ac_cell(input logic [6:0] a);
        return {a[6], a[3:0]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_hd44780_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : lcd_hd44780_responder_if
// Description : HD44780 character bus between the LCD host controller
//               (master) and the display-side responder (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface lcd_hd44780_responder_if;

    logic       LCD_EN;
    logic       LCD_RS;
    logic       LCD_RW;
    logic [7:0] LCD_DATA_IN;
    logic [7:0] LCD_DATA_OUT;
    logic       LCD_DATA_OE;

    modport master (
        output LCD_EN, LCD_RS, LCD_RW, LCD_DATA_IN,
        input  LCD_DATA_OUT, LCD_DATA_OE
    );

    modport slave (
        input  LCD_EN, LCD_RS, LCD_RW, LCD_DATA_IN,
        output LCD_DATA_OUT, LCD_DATA_OE
    );

endinterface
`default_nettype wire

// File: rtl/lcd_ddram.sv
`default_nettype none
// ============================================================================
// Module      : lcd_ddram
// Description : 32x8 display data RAM. One write port shared by bus writes
//               and the clear sweep, a registered host mirror read port and
//               an asynchronous bus read port.
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_ddram
    import lcd_pkg::*;
(
    input  wire logic              iCLK,
    input  wire logic              iRST_N,
    input  wire logic              wr_en,
    input  wire logic [ADDR_W-1:0] wr_addr,
    input  wire logic [7:0]        wr_data,
    input  wire logic [ADDR_W-1:0] host_addr,
    output logic      [7:0]        host_data,
    input  wire logic [ADDR_W-1:0] bus_addr,
    output logic      [7:0]        bus_data
);

    logic [7:0] mem [DDRAM_DEPTH];

    // Storage write; contents are initialised by the clear sweep, not by reset
    always_ff @(posedge iCLK) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Host mirror read; a same-cycle write to the cell returns the old value
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            host_data <= 8'h00;
        end else begin
            host_data <= mem[host_addr];
        end
    end

    assign bus_data = mem[bus_addr];

endmodule
`default_nettype wire

// File: rtl/lcd_hd44780_responder.sv
`default_nettype none
// ============================================================================
// Module      : lcd_hd44780_responder
// Description : Display-side model of an HD44780 character LCD. Samples the
//               host bus through synchronizers, decodes instructions, keeps
//               the DDRAM image, address counter and busy flag, and answers
//               status and data reads.
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_hd44780_responder
    import lcd_pkg::*;
#(
    parameter int BUSY_CYCLES  = 2000,
    parameter int CLEAR_CYCLES = 82000   // must be at least 32
) (
    input  wire logic              iCLK,
    input  wire logic              iRST_N,
    lcd_hd44780_responder_if.slave bus,
    input  wire logic [4:0]        iRdAddr,
    output logic      [7:0]        oRdChar,
    output logic                   oBusy,
    output logic                   oDisplayOn,
    output logic                   oTwoLine,
    output logic                   oOverrun
);

    localparam int CNT_MAX = (CLEAR_CYCLES > BUSY_CYCLES) ? CLEAR_CYCLES : BUSY_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0]  BUSY_LOAD  = CNT_W'(BUSY_CYCLES);
    localparam logic [CNT_W-1:0]  CLEAR_LOAD = CNT_W'(CLEAR_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
    localparam logic [ADDR_W-1:0] SWEEP_LAST = ADDR_W'(DDRAM_DEPTH - 1);

    // Synchronized bus view: {EN, RS, RW, DATA}
    logic [10:0] sync_meta;
    logic [10:0] sync_q;
    logic        en_prev;
    logic        en_s;
    logic        rs_s;
    logic        rw_s;
    logic [7:0]  data_s;
    logic        commit;
    logic        wr_commit;
    logic        rd_commit;
    instr_t      instr;

    // Architectural state and its next values
    state_t              state,      state_n;
    logic [CNT_W-1:0]    busy_cnt,   busy_cnt_n;
    logic [ADDR_W-1:0]   sweep_idx,  sweep_idx_n;
    logic [6:0]          ac,         ac_n;
    logic                inc_mode,   inc_mode_n;
    logic                display_on, display_on_n;
    logic                two_line,   two_line_n;
    logic                overrun,    overrun_n;
    logic [7:0]          data_out,   data_out_n;
    logic                data_oe,    data_oe_n;

    // DDRAM port controls
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [7:0]          mem_wdata;
    logic [7:0]          mem_bus_data;
    logic [7:0]          cell_value;

    // Two-flop synchronizers on every bus input, plus delayed EN for edge detection
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            sync_meta <= '0;
            sync_q    <= '0;
            en_prev   <= 1'b0;
        end else begin
            sync_meta <= {bus.LCD_EN, bus.LCD_RS, bus.LCD_RW, bus.LCD_DATA_IN};
            sync_q    <= sync_meta;
            en_prev   <= en_s;
        end
    end

    assign en_s      = sync_q[10];
    assign rs_s      = sync_q[9];
    assign rw_s      = sync_q[8];
    assign data_s    = sync_q[7:0];
    assign commit    = en_prev & ~en_s;
    assign wr_commit = commit & ~rw_s;
    assign rd_commit = commit & rw_s;
    assign instr     = instr_decode(data_s);

    // Cells outside the visible window read back as blanks
    assign cell_value = ac_visible(ac) ? mem_bus_data : SPACE;

    // Next-state, register updates and DDRAM write selection
    always_comb begin
        state_n      = state;
        busy_cnt_n   = busy_cnt;
        sweep_idx_n  = sweep_idx;
        ac_n         = ac;
        inc_mode_n   = inc_mode;
        display_on_n = display_on;
        two_line_n   = two_line;
        overrun_n    = overrun;
        mem_we       = 1'b0;
        mem_waddr    = sweep_idx;
        mem_wdata    = SPACE;

        unique case (state)
            CLEARING: begin
                mem_we      = 1'b1;
                busy_cnt_n  = CLEAR_LOAD;
                sweep_idx_n = sweep_idx + 1'b1;
                if (sweep_idx == SWEEP_LAST) begin
                    state_n = BUSY;
                end
            end
            BUSY: begin
                // The last busy cycle is the one in which the count reaches zero
                if (busy_cnt <= CNT_ONE) begin
                    state_n    = IDLE;
                    busy_cnt_n = '0;
                end else begin
                    busy_cnt_n = busy_cnt - CNT_ONE;
                end
            end
            IDLE: begin
                if (wr_commit) begin
                    state_n    = BUSY;
                    busy_cnt_n = BUSY_LOAD;
                    if (rs_s) begin
                        mem_we    = ac_visible(ac);
                        mem_waddr = ac_cell(ac);
                        mem_wdata = data_s;
                        ac_n      = ac_step(ac, inc_mode);
                    end else begin
                        unique case (instr)
                            INS_CLEAR: begin
                                state_n     = CLEARING;
                                sweep_idx_n = '0;
                                busy_cnt_n  = CLEAR_LOAD;
                                ac_n        = LINE0_BASE;
                                inc_mode_n  = 1'b1;
                            end
                            INS_HOME: begin
                                ac_n       = LINE0_BASE;
                                busy_cnt_n = CLEAR_LOAD;
                            end
                            INS_ENTRY:   inc_mode_n   = data_s[1];
                            INS_DISPCTL: display_on_n = data_s[2];
                            INS_SHIFT: begin
                                // Only cursor moves are modelled; display shifts are ignored
                                if (!data_s[3]) begin
                                    ac_n = ac_step(ac, data_s[2]);
                                end
                            end
                            INS_FUNCSET: two_line_n = data_s[3];
                            INS_DDRAM:   ac_n       = data_s[6:0];
                            default: ;
                        endcase
                    end
                end else if (rd_commit && rs_s) begin
                    ac_n = ac_step(ac, inc_mode);
                end
            end
            default: begin
                state_n     = CLEARING;
                sweep_idx_n = '0;
            end
        endcase

        if (wr_commit && (state != IDLE)) begin
            overrun_n = 1'b1;
        end

        // Read data follows the synced strobe; status reflects the live busy flag
        data_oe_n  = en_s & rw_s;
        data_out_n = 8'h00;
        if (en_s && rw_s) begin
            data_out_n = rs_s ? cell_value : {(state != IDLE), ac};
        end
    end

    // State register
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state      <= CLEARING;
            busy_cnt   <= CLEAR_LOAD;
            sweep_idx  <= '0;
            ac         <= LINE0_BASE;
            inc_mode   <= 1'b1;
            display_on <= 1'b0;
            two_line   <= 1'b0;
            overrun    <= 1'b0;
            data_out   <= 8'h00;
            data_oe    <= 1'b0;
        end else begin
            state      <= state_n;
            busy_cnt   <= busy_cnt_n;
            sweep_idx  <= sweep_idx_n;
            ac         <= ac_n;
            inc_mode   <= inc_mode_n;
            display_on <= display_on_n;
            two_line   <= two_line_n;
            overrun    <= overrun_n;
            data_out   <= data_out_n;
            data_oe    <= data_oe_n;
        end
    end

    lcd_ddram u_ddram (
        .iCLK      (iCLK),
        .iRST_N    (iRST_N),
        .wr_en     (mem_we),
        .wr_addr   (mem_waddr),
        .wr_data   (mem_wdata),
        .host_addr (iRdAddr),
        .host_data (oRdChar),
        .bus_addr  (ac_cell(ac)),
        .bus_data  (mem_bus_data)
    );

    assign bus.LCD_DATA_OUT = data_out;
    assign bus.LCD_DATA_OE  = data_oe;
    assign oBusy            = (state != IDLE);
    assign oDisplayOn       = display_on;
    assign oTwoLine         = two_line;
    assign oOverrun         = overrun;

endmodule
`default_nettype wire

// File: tb/tb_lcd_hd44780_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_lcd_hd44780_responder
// Description : Directed and randomized bench for the HD44780 responder with
//               a behavioural display model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lcd_hd44780_responder;

    localparam int BUSY_CYC  = 40;
    localparam int CLEAR_CYC = 100;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] rd_addr = 5'd0;
    logic [7:0] rd_char;
    logic       busy, disp_on, two_line, overrun;

    always #5 clk = ~clk;

    lcd_hd44780_responder_if bus ();

    lcd_hd44780_responder #(
        .BUSY_CYCLES  (BUSY_CYC),
        .CLEAR_CYCLES (CLEAR_CYC)
    ) dut (
        .iCLK       (clk),
        .iRST_N     (rst_n),
        .bus        (bus),
        .iRdAddr    (rd_addr),
        .oRdChar    (rd_char),
        .oBusy      (busy),
        .oDisplayOn (disp_on),
        .oTwoLine   (two_line),
        .oOverrun   (overrun)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Behavioural display model
    logic [7:0] m_ram [32];
    int         m_ac;
    bit         m_inc, m_disp, m_two, m_ovr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_visible(input int a);
        return (a < 16) || (a >= 64 && a < 80);
    endfunction

    function automatic int m_cell(input int a);
        return (a < 16) ? a : a - 48;
    endfunction

    function automatic int m_step(input int a, input bit inc);
        if (inc) begin
            if (a == 39)  return 64;
            if (a == 103) return 0;
            return (a + 1) % 128;
        end
        if (a == 0)  return 103;
        if (a == 64) return 39;
        return a - 1;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 32; i++) m_ram[i] = 8'h20;
        m_ac = 0; m_inc = 1; m_disp = 0; m_two = 0; m_ovr = 0;
    endtask

    // Effect of an accepted write, by instruction value range
    task automatic m_write(input bit rs, input logic [7:0] d);
        int v;
        v = int'(d);
        if (rs) begin
            if (m_visible(m_ac)) m_ram[m_cell(m_ac)] = d;
            m_ac = m_step(m_ac, m_inc);
        end else if (v == 1) begin
            for (int i = 0; i < 32; i++) m_ram[i] = 8'h20;
            m_ac = 0; m_inc = 1;
        end else if (v >= 2 && v < 4)   m_ac = 0;
        else if (v >= 4 && v < 8)       m_inc = d[1];
        else if (v >= 8 && v < 16)      m_disp = d[2];
        else if (v >= 16 && v < 32) begin
            if (!d[3]) m_ac = m_step(m_ac, d[2]);
        end else if (v >= 32 && v < 64) m_two = d[3];
        else if (v >= 128)              m_ac = v - 128;
    endtask

    task automatic bus_write(input bit rs, input logic [7:0] d);
        @(negedge clk);
        bus.LCD_RS = rs; bus.LCD_RW = 1'b0; bus.LCD_DATA_IN = d; bus.LCD_EN = 1'b1;
        repeat (4) @(negedge clk);
        bus.LCD_EN = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic bus_read(input bit rs, output logic [7:0] v);
        int n;
        @(negedge clk);
        bus.LCD_RS = rs; bus.LCD_RW = 1'b1; bus.LCD_EN = 1'b1;
        n = 0;
        while (bus.LCD_DATA_OE !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("oe_rise", {31'd0, bus.LCD_DATA_OE}, 32'd1);
        @(negedge clk);
        v = bus.LCD_DATA_OUT;
        bus.LCD_EN = 1'b0;
        repeat (4) @(negedge clk);
        check("oe_fall", {31'd0, bus.LCD_DATA_OE}, 32'd0);
        bus.LCD_RW = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) check("idle_timeout", {31'd0, busy}, 32'd0);
    endtask

    task automatic host_write(input bit rs, input logic [7:0] d);
        wait_idle();
        bus_write(rs, d);
        m_write(rs, d);
        wait_idle();
    endtask

    task automatic check_status(input string tag);
        logic [7:0] v;
        bus_read(1'b0, v);
        check(tag, {24'd0, v}, 32'(m_ac));
    endtask

    task automatic check_cell(input int a);
        @(negedge clk);
        rd_addr = 5'(a);
        @(negedge clk);
        check($sformatf("mirror[%0d]", a), {24'd0, rd_char}, {24'd0, m_ram[a]});
    endtask

    task automatic check_all_cells();
        for (int a = 0; a < 32; a++) check_cell(a);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_oe"},   {31'd0, bus.LCD_DATA_OE}, 32'd0);
        check({tag, "_dout"}, {24'd0, bus.LCD_DATA_OUT}, 32'd0);
        check({tag, "_rdch"}, {24'd0, rd_char}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd1);
        check({tag, "_disp"}, {31'd0, disp_on}, 32'd0);
        check({tag, "_two"},  {31'd0, two_line}, 32'd0);
        check({tag, "_ovr"},  {31'd0, overrun}, 32'd0);
    endtask

    // Release reset on a falling edge and count rising edges until busy drops
    task automatic release_and_measure(input string tag);
        int n;
        @(negedge clk);
        rst_n = 1'b1;
        m_reset();
        n = 0;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end while (busy === 1'b1 && n < 32 + CLEAR_CYC + 50);
        check(tag, 32'(n), 32'(32 + CLEAR_CYC));
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] v;
        string      word;
        int         op;
        logic [7:0] d;

        bus.LCD_EN = 1'b0; bus.LCD_RS = 1'b0; bus.LCD_RW = 1'b0; bus.LCD_DATA_IN = 8'h00;
        m_reset();

        // 1. Reset state, sweep length, blank DDRAM, idle status
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        release_and_measure("sweep_len");
        check_all_cells();
        check_status("status_after_reset");

        // 2. Init sequence and "Parado"
        host_write(1'b0, 8'h38);
        host_write(1'b0, 8'h0C);
        host_write(1'b0, 8'h01);
        host_write(1'b0, 8'h06);
        host_write(1'b0, 8'h80);
        word = "Parado";
        for (int i = 0; i < word.len(); i++) host_write(1'b1, word[i]);
        check("two_line", {31'd0, two_line}, 32'd1);
        check("disp_on",  {31'd0, disp_on},  32'd1);
        check("overrun0", {31'd0, overrun},  32'd0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            rd_addr = 5'(i);
            @(negedge clk);
            check($sformatf("parado[%0d]", i), {24'd0, rd_char}, {24'd0, word[i]});
        end
        check_cell(6);

        // 3. Line 1 write and busy-flag read
        host_write(1'b0, 8'hC0);
        wait_idle();
        bus_write(1'b1, 8'h44);
        m_write(1'b1, 8'h44);
        bus_read(1'b0, v);
        check("busy_read", {24'd0, v}, 32'h0000_00C1);
        wait_idle();
        check_status("status_line1");
        check_cell(16);

        // 4. Address counter wrap on increment and decrement
        host_write(1'b0, 8'hA7);
        host_write(1'b1, 8'h58);
        check_status("wrap_inc");
        host_write(1'b0, 8'h04);
        host_write(1'b0, 8'h80);
        host_write(1'b1, 8'h2A);
        check_status("wrap_dec");
        host_write(1'b0, 8'h06);
        check_all_cells();

        // 5. Write while busy is discarded and flags overrun permanently
        host_write(1'b0, 8'h85);
        bus_write(1'b1, 8'h41);
        bus_write(1'b1, 8'h5A);
        m_write(1'b1, 8'h41);
        m_ovr = 1;
        check("overrun_set", {31'd0, overrun}, {31'd0, m_ovr});
        wait_idle();
        check_cell(5);
        check_cell(6);
        check_status("status_after_overrun");
        host_write(1'b1, 8'h42);
        check("overrun_sticky", {31'd0, overrun}, {31'd0, m_ovr});

        // Randomized commands against the model
        for (int k = 0; k < 60; k++) begin
            op = $urandom_range(0, 9);
            if (op <= 3) begin
                host_write(1'b1, 8'($urandom_range(32, 126)));
            end else if (op == 4) begin
                d = 8'($urandom_range(0, 127));
                if ($urandom_range(0, 1) == 1) d = {1'b0, d[6], 2'b00, d[3:0]};
                host_write(1'b0, 8'h80 | d);
            end else if (op == 5) begin
                host_write(1'b0, 8'h04 | 8'($urandom_range(0, 3)));
            end else if (op == 6) begin
                host_write(1'b0, 8'h10 | 8'($urandom_range(0, 15)));
            end else if (op == 7) begin
                wait_idle();
                bus_read(1'b1, v);
                check("data_read", {24'd0, v},
                      {24'd0, m_visible(m_ac) ? m_ram[m_cell(m_ac)] : 8'h20});
                m_ac = m_step(m_ac, m_inc);
            end else if (op == 8) begin
                host_write(1'b0, 8'($urandom_range(2, 127)));
            end else if ($urandom_range(0, 3) == 0) begin
                host_write(1'b0, 8'h01);
            end
            check_status("rand_status");
            check("rand_disp", {31'd0, disp_on},  {31'd0, m_disp});
            check("rand_two",  {31'd0, two_line}, {31'd0, m_two});
            check_cell($urandom_range(0, 31));
        end
        check_all_cells();
        check("overrun_end", {31'd0, overrun}, {31'd0, m_ovr});

        // 6a. Reset in the middle of a clear sweep
        wait_idle();
        bus_write(1'b0, 8'h01);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("rst_clear");
        repeat (3) @(negedge clk);
        release_and_measure("sweep_len_2");

        // 6b. Reset in the middle of a bus read
        host_write(1'b1, 8'h55);
        @(negedge clk);
        bus.LCD_RS = 1'b1; bus.LCD_RW = 1'b1; bus.LCD_EN = 1'b1;
        repeat (5) @(negedge clk);
        check("oe_before_rst", {31'd0, bus.LCD_DATA_OE}, 32'd1);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("rst_read");
        bus.LCD_EN = 1'b0; bus.LCD_RW = 1'b0;
        repeat (3) @(negedge clk);
        release_and_measure("sweep_len_3");
        check_all_cells();
        check_status("status_after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
